// File: rtl/neighbor_qtable.sv
// neighbor_qtable: captures Q-values advertised by neighbouring nodes into a
// dense table and reports the neighbour with the highest advertised Q-value
// (ties resolve to the lowest table index) together with its Q and hop count.
module neighbor_qtable #(
    parameter int WORD_WIDTH    = 16,
    parameter int NUM_NEIGHBORS = 8,
    localparam int IDX_W        = $clog2(NUM_NEIGHBORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [WORD_WIDTH-1:0] pkt_nodeID,
    input  logic [WORD_WIDTH-1:0] pkt_QValue,
    input  logic [WORD_WIDTH-1:0] pkt_hops,
    input  logic                  clear_table,
    output logic                  bestHop_valid,
    output logic [WORD_WIDTH-1:0] bestHop_ID,
    output logic [WORD_WIDTH-1:0] bestHop_QValue,
    output logic [WORD_WIDTH-1:0] bestHop_hops,
    output logic [IDX_W:0]        neighborCount,
    output logic                  table_full,
    output logic                  drop_pulse
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(NUM_NEIGHBORS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_WRITE  = 2'd2,
        ST_SCAN   = 2'd3
    } state_t;

    state_t                r_state;
    logic [IDX_W:0]        r_idx;
    logic [IDX_W:0]        r_count;
    logic [IDX_W-1:0]      r_target;
    logic                  r_new;
    logic [WORD_WIDTH-1:0] r_lat_id;
    logic [WORD_WIDTH-1:0] r_lat_q;
    logic [WORD_WIDTH-1:0] r_lat_hops;
    logic [WORD_WIDTH-1:0] r_max_id;
    logic [WORD_WIDTH-1:0] r_max_q;
    logic [WORD_WIDTH-1:0] r_max_hops;
    logic                  r_best_valid;
    logic [WORD_WIDTH-1:0] r_best_id;
    logic [WORD_WIDTH-1:0] r_best_q;
    logic [WORD_WIDTH-1:0] r_best_hops;
    logic                  r_drop;

    logic [WORD_WIDTH-1:0] r_tab_id   [NUM_NEIGHBORS];
    logic [WORD_WIDTH-1:0] r_tab_q    [NUM_NEIGHBORS];
    logic [WORD_WIDTH-1:0] r_tab_hops [NUM_NEIGHBORS];

    logic [WORD_WIDTH-1:0] w_rd_id;
    logic [WORD_WIDTH-1:0] w_rd_q;
    logic [WORD_WIDTH-1:0] w_rd_hops;
    logic                  w_full;
    logic                  w_take;
    logic [WORD_WIDTH-1:0] w_cand_id;
    logic [WORD_WIDTH-1:0] w_cand_q;
    logic [WORD_WIDTH-1:0] w_cand_hops;

    assign w_full    = (r_count == FULL_CNT);
    assign w_rd_id   = r_tab_id[r_idx[IDX_W-1:0]];
    assign w_rd_q    = r_tab_q[r_idx[IDX_W-1:0]];
    assign w_rd_hops = r_tab_hops[r_idx[IDX_W-1:0]];

    // Running-maximum candidate: entry 0 seeds the scan, later entries replace only on strictly greater Q
    always_comb begin
        w_take      = (r_idx == '0) || (w_rd_q > r_max_q);
        w_cand_id   = r_max_id;
        w_cand_q    = r_max_q;
        w_cand_hops = r_max_hops;
        if (w_take) begin
            w_cand_id   = w_rd_id;
            w_cand_q    = w_rd_q;
            w_cand_hops = w_rd_hops;
        end
    end

    // Table storage: contents need no reset because occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (r_state == ST_WRITE && !clear_table && !rst) begin
            r_tab_id[r_target]   <= r_lat_id;
            r_tab_q[r_target]    <= r_lat_q;
            r_tab_hops[r_target] <= r_lat_hops;
        end
    end

    // Control FSM: accept, search for existing ID, write entry, rescan for best hop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_count      <= '0;
            r_target     <= '0;
            r_new        <= 1'b0;
            r_lat_id     <= '0;
            r_lat_q      <= '0;
            r_lat_hops   <= '0;
            r_max_id     <= '0;
            r_max_q      <= '0;
            r_max_hops   <= '0;
            r_best_valid <= 1'b0;
            r_best_id    <= '0;
            r_best_q     <= '0;
            r_best_hops  <= '0;
            r_drop       <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (clear_table) begin
                r_state      <= ST_IDLE;
                r_count      <= '0;
                r_best_valid <= 1'b0;
                r_best_id    <= '0;
                r_best_q     <= '0;
                r_best_hops  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (pkt_valid) begin
                            r_lat_id   <= pkt_nodeID;
                            r_lat_q    <= pkt_QValue;
                            r_lat_hops <= pkt_hops;
                            r_idx      <= '0;
                            r_state    <= ST_SEARCH;
                        end
                    end
                    ST_SEARCH: begin
                        if (r_idx == r_count) begin
                            if (w_full) begin
                                r_drop  <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_target <= r_count[IDX_W-1:0];
                                r_new    <= 1'b1;
                                r_state  <= ST_WRITE;
                            end
                        end else if (w_rd_id == r_lat_id) begin
                            r_target <= r_idx[IDX_W-1:0];
                            r_new    <= 1'b0;
                            r_state  <= ST_WRITE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        if (r_new) begin
                            r_count <= r_count + 1'b1;
                        end
                        r_idx   <= '0;
                        r_state <= ST_SCAN;
                    end
                    ST_SCAN: begin
                        if (r_idx == r_count - 1'b1) begin
                            r_best_valid <= 1'b1;
                            r_best_id    <= w_cand_id;
                            r_best_q     <= w_cand_q;
                            r_best_hops  <= w_cand_hops;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_max_id   <= w_cand_id;
                            r_max_q    <= w_cand_q;
                            r_max_hops <= w_cand_hops;
                            r_idx      <= r_idx + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign pkt_ready      = (r_state == ST_IDLE);
    assign bestHop_valid  = r_best_valid;
    assign bestHop_ID     = r_best_id;
    assign bestHop_QValue = r_best_q;
    assign bestHop_hops   = r_best_hops;
    assign neighborCount  = r_count;
    assign table_full     = w_full;
    assign drop_pulse     = r_drop;

endmodule

// File: tb/tb_neighbor_qtable.sv
// Directed bench for neighbor_qtable: hand-computed best-hop results and
// cycle-exact latencies for insert, tie, overwrite, drop, clear and reset.
module tb_neighbor_qtable;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [15:0] pkt_nodeID = '0;
    logic [15:0] pkt_QValue = '0;
    logic [15:0] pkt_hops = '0;
    logic        clear_table = 1'b0;
    logic        bestHop_valid;
    logic [15:0] bestHop_ID;
    logic [15:0] bestHop_QValue;
    logic [15:0] bestHop_hops;
    logic [3:0]  neighborCount;
    logic        table_full;
    logic        drop_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    neighbor_qtable #(.WORD_WIDTH(16), .NUM_NEIGHBORS(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_nodeID     (pkt_nodeID),
        .pkt_QValue     (pkt_QValue),
        .pkt_hops       (pkt_hops),
        .clear_table    (clear_table),
        .bestHop_valid  (bestHop_valid),
        .bestHop_ID     (bestHop_ID),
        .bestHop_QValue (bestHop_QValue),
        .bestHop_hops   (bestHop_hops),
        .neighborCount  (neighborCount),
        .table_full     (table_full),
        .drop_pulse     (drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one packet; acceptance edge is T, best-hop update expected at T+lat
    task automatic send(input logic [15:0] id, input logic [15:0] q, input logic [15:0] hops,
                        input int lat);
        int w;
        w = 0;
        while (!pkt_ready && w < 50) begin
            tick();
            w++;
        end
        chk("ready_before_send", 32'(pkt_ready), 32'd1);
        pkt_valid  = 1'b1;
        pkt_nodeID = id;
        pkt_QValue = q;
        pkt_hops   = hops;
        tick();
        pkt_valid = 1'b0;
        for (int c = 1; c < lat; c++) begin
            tick();
            chk("ready_low_busy", 32'(pkt_ready), 32'd0);
        end
        tick();
        chk("ready_at_update", 32'(pkt_ready), 32'd1);
    endtask

    task automatic chk_best(input logic [15:0] id, input logic [15:0] q, input logic [15:0] hops,
                            input logic [3:0] cnt);
        chk("best_valid", 32'(bestHop_valid), 32'd1);
        chk("best_id",    32'(bestHop_ID), 32'(id));
        chk("best_q",     32'(bestHop_QValue), 32'(q));
        chk("best_hops",  32'(bestHop_hops), 32'(hops));
        chk("count",      32'(neighborCount), 32'(cnt));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(pkt_ready), 32'd1);
        chk({tag, "_valid"}, 32'(bestHop_valid), 32'd0);
        chk({tag, "_id"},    32'(bestHop_ID), 32'd0);
        chk({tag, "_q"},     32'(bestHop_QValue), 32'd0);
        chk({tag, "_hops"},  32'(bestHop_hops), 32'd0);
        chk({tag, "_count"}, 32'(neighborCount), 32'd0);
        chk({tag, "_full"},  32'(table_full), 32'd0);
        chk({tag, "_drop"},  32'(drop_pulse), 32'd0);
    endtask

    initial begin
        #12;
        chk_reset_state("reset");
        rst = 1'b0;
        tick();

        // First insert into empty table: update at T+3
        send(16'd5, 16'h4000, 16'd3, 3);
        chk_best(16'd5, 16'h4000, 16'd3, 4'd1);

        // Count 1 -> 2: latency 2*1+3; count 2 -> 3: latency 2*2+3, tie keeps ID 7
        send(16'd7, 16'h6000, 16'd2, 5);
        chk_best(16'd7, 16'h6000, 16'd2, 4'd2);
        send(16'd9, 16'h6000, 16'd4, 7);
        chk_best(16'd7, 16'h6000, 16'd2, 4'd3);

        // Overwrite ID 7 (index 1) with lower Q: latency 2+1+3, best moves to 9
        send(16'd7, 16'h1000, 16'd2, 6);
        chk_best(16'd9, 16'h6000, 16'd4, 4'd3);
        chk("not_full_3", 32'(table_full), 32'd0);

        // Fill remaining five slots with low Q values
        for (int k = 0; k < 5; k++) begin
            send(16'(20 + k), 16'(16'h0100 + k), 16'd1, 2 * (3 + k) + 3);
            chk_best(16'd9, 16'h6000, 16'd4, 4'(4 + k));
        end
        chk("full_after_fill", 32'(table_full), 32'd1);

        // New ID on full table: drop pulse at T+9 for exactly one cycle
        pkt_valid  = 1'b1;
        pkt_nodeID = 16'd99;
        pkt_QValue = 16'hFFFF;
        pkt_hops   = 16'd1;
        tick();
        pkt_valid = 1'b0;
        for (int c = 1; c < 9; c++) begin
            tick();
            chk("drop_early", 32'(drop_pulse), 32'd0);
        end
        tick();
        chk("drop_pulse_T9", 32'(drop_pulse), 32'd1);
        chk("drop_ready_T9", 32'(pkt_ready), 32'd1);
        tick();
        chk("drop_pulse_end", 32'(drop_pulse), 32'd0);
        chk_best(16'd9, 16'h6000, 16'd4, 4'd8);
        chk("full_after_drop", 32'(table_full), 32'd1);

        // Clear mid-SCAN: match at index 0 of full table, scan runs T+3..T+10
        pkt_valid  = 1'b1;
        pkt_nodeID = 16'd5;
        pkt_QValue = 16'h5000;
        pkt_hops   = 16'd3;
        tick();
        pkt_valid = 1'b0;
        repeat (4) tick();
        clear_table = 1'b1;
        tick();
        clear_table = 1'b0;
        chk_reset_state("clear");

        // Two entries, then async reset during SEARCH of a third
        send(16'd1, 16'h0100, 16'd6, 3);
        send(16'd2, 16'h0300, 16'd7, 5);
        chk_best(16'd2, 16'h0300, 16'd7, 4'd2);
        pkt_valid  = 1'b1;
        pkt_nodeID = 16'd50;
        pkt_QValue = 16'h7000;
        pkt_hops   = 16'd2;
        tick();
        pkt_valid = 1'b0;
        tick();
        chk("search_busy", 32'(pkt_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk_reset_state("async_rst");
        #2 rst = 1'b0;
        tick();

        send(16'd5, 16'h4000, 16'd3, 3);
        chk_best(16'd5, 16'h4000, 16'd3, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neighbor_qtable.md
# neighbor_qtable

Receive-side counterpart of the node's Q-value computation in the EER-RL routing engine. It captures Q-values advertised by neighbouring nodes, stores one entry per neighbour, and continuously reports the best next hop (highest advertised Q) plus that neighbour's Q and hop count. These feed the Q-value update term `y*[besthop]Q` and the node's own hops-from-sink derivation.

## Interface

Parameters:
- `WORD_WIDTH`, default 16: width of node IDs, Q-values and hop counts. Q-values are unsigned fixed-point and compared as plain unsigned integers.
- `NUM_NEIGHBORS`, default 8: number of table entries; `IDX_W = $clog2(NUM_NEIGHBORS)`.

Ports (name, direction, width, meaning):
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `pkt_valid` input 1: advertised packet fields are valid.
- `pkt_ready` output 1: block can accept a packet.
- `pkt_nodeID` input WORD_WIDTH: sender node ID.
- `pkt_QValue` input WORD_WIDTH: sender's advertised Q-value.
- `pkt_hops` input WORD_WIDTH: sender's hops from sink.
- `clear_table` input 1: synchronous table flush.
- `bestHop_valid` output 1: best-hop outputs hold a valid neighbour.
- `bestHop_ID` output WORD_WIDTH: ID of the best neighbour.
- `bestHop_QValue` output WORD_WIDTH: Q-value of the best neighbour.
- `bestHop_hops` output WORD_WIDTH: hop count of the best neighbour.
- `neighborCount` output IDX_W+1: number of occupied entries, 0..NUM_NEIGHBORS.
- `table_full` output 1: `neighborCount == NUM_NEIGHBORS`.
- `drop_pulse` output 1: one-cycle pulse when a new-ID packet is discarded because the table is full.

## Operation

- Table: `NUM_NEIGHBORS` entries of {ID, QValue, hops}. Entries 0..count-1 are occupied and filled densely; there is no per-entry delete.
- FSM states: IDLE, SEARCH, WRITE, SCAN.
- IDLE:
  - `pkt_ready = 1`; it is 0 in every other state.
  - On `pkt_valid && pkt_ready`, latch all three packet fields, set index i = 0, and go to SEARCH.
- SEARCH: inspects one index per cycle.
  - If i == count: no match.
    - If the table is not full, the target is index `count`, count increments at the WRITE edge, and the FSM goes to WRITE.
    - If the table is full, pulse `drop_pulse`, leave the table and best-hop outputs unchanged, and return to IDLE.
  - Otherwise, if ID[i] == latched ID: the target is i; go to WRITE.
  - Otherwise: i++.
- WRITE: write the latched {ID, QValue, hops} to the target entry in one cycle (overwrite on match), then go to SCAN with i = 0.
- SCAN:
  - One entry per cycle over 0..count-1, tracking a running maximum QValue.
  - The replacement rule is strict greater-than, so ties resolve to the lowest index.
  - On the last entry, register best ID/Q/hops, set `bestHop_valid = 1`, and return to IDLE.
  - Rescanning after every write is required because an overwrite can lower the current best.
- `clear_table`: highest priority in every state. At the edge it aborts any operation, sets count = 0, `bestHop_valid = 0`, clears the best outputs to 0, and moves the FSM to IDLE. A packet presented on the same cycle as `clear_table` is not accepted.
- `rst`: asynchronously forces the same state as `clear_table`.
  - Reset values: FSM IDLE, `pkt_ready = 1`, `bestHop_valid = 0`, `bestHop_ID`/`bestHop_QValue`/`bestHop_hops` = 0, `neighborCount = 0`, `table_full = 0`, `drop_pulse = 0`.
  - Table contents are don't-care.

## Timing

- Acceptance edge T (IDLE sampled handshake).
- SEARCH duration: k+1 cycles for a match at index k; count+1 cycles for no match (1 cycle when the table is empty).
- WRITE duration: 1 cycle.
- SCAN duration: count' cycles, where count' is the count after the write (≥1).
- Best-hop outputs update at edge T + SEARCH + 1 + count'. For an empty table this is T+3. `pkt_ready` returns high at the same edge.
- Drop case: `drop_pulse` is high for exactly one cycle, starting at edge T + NUM_NEIGHBORS + 1. `pkt_ready` is high from that same edge.
- Best-hop outputs are stable between updates. No output is combinational from `pkt_*` inputs.
- `neighborCount` and `table_full` change at the WRITE edge.

## Test plan

- Reset, then accept {ID=5, Q=0x4000, hops=3} → at T+3: `bestHop_valid = 1`, `bestHop_ID = 5`, `bestHop_QValue = 0x4000`, `bestHop_hops = 3`, `neighborCount = 1`; `pkt_ready` is low from T+1 to T+2.
- Add ID=7 (Q=0x6000, hops 2), then ID=9 (Q=0x6000, hops 4) → best = 7 (tie keeps the lower index); count = 3.
- Re-send ID=7 with Q=0x1000 → count stays 3, best becomes 9 (Q 0x6000). Check the update edge matches T + 2 + 1 + 3.
- Fill all 8 entries, then send new ID=99 → `drop_pulse` high for 1 cycle at T+9; table and best unchanged; `table_full = 1`.
- Assert `clear_table` mid-SCAN → next cycle: count = 0, `bestHop_valid = 0`, all best outputs 0, `pkt_ready = 1`.
- Assert `rst` asynchronously mid-SEARCH → outputs return to reset values immediately; the first packet after deassertion behaves as in the first scenario.
